// File: rtl/result_display_pkg.sv
// rtl/result_display_pkg.sv - shared types, constants and helpers for the result display sequencer
//
// Purpose: FSM state encoding, the default dwell for a 5 s display at 12 MHz,
// and the width helper for the dwell counter.
package result_display_pkg;

  typedef enum logic {
    FILL = 1'b0,
    SHOW = 1'b1
  } state_e;

  localparam int DWELL_5S_12MHZ = 60_000_000;

  // Counter width able to hold 0..dwell_p.
  function automatic int dwell_width(input int dwell_p);
    return $clog2(dwell_p + 1);
  endfunction

endpackage

// File: rtl/result_display_sequencer_dwell_timer.sv
// rtl/result_display_sequencer_dwell_timer.sv - per-entry dwell counter with hold and clear
//
// Purpose: counts cycles an entry has been on display and pulses expire_o on
// the final cycle of the dwell period.
// Ports:
//   clk_i      in   clock, rising edge
//   reset_n_i  in   asynchronous active-low reset
//   clear_i    in   restart the count from zero on the next edge
//   hold_i     in   freeze the count (also suppresses expiry)
//   expire_o   out  high for the single cycle where count == dwell_p-1 and not held
module dwell_timer
  import result_display_pkg::*;
#(
  parameter int dwell_p = DWELL_5S_12MHZ
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clear_i,
  input  logic hold_i,
  output logic expire_o
);

  localparam int                  cnt_w_lp = dwell_width(dwell_p);
  localparam logic [cnt_w_lp-1:0] term_lp  = cnt_w_lp'(dwell_p - 1);

  logic [cnt_w_lp-1:0] count_q;
  logic [cnt_w_lp-1:0] count_d;

  assign expire_o = !hold_i && (count_q == term_lp);

  // Expiry wraps to zero on its own so the pulse is one cycle long even if
  // the caller does not clear.
  always_comb begin
    count_d = count_q;
    if (clear_i || expire_o) begin
      count_d = '0;
    end else if (!hold_i) begin
      count_d = count_q + cnt_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/result_display_sequencer.sv
// rtl/result_display_sequencer.sv - frame buffer and timed display sequencer for result entries
//
// Purpose: collects width_p-bit results into a frame of up to depth_p entries,
// then shows each entry for dwell_p cycles (or until step_i), with hold and
// abort controls. Optional macro RESULT_DISPLAY_LOOP_EN makes the frame loop
// until aborted instead of returning to FILL after one pass.
// Ports:
//   clk_i      in   clock, rising edge
//   reset_n_i  in   asynchronous active-low reset
//   valid_i    in   data_i carries a result
//   data_i     in   result entry
//   ready_o    out  an entry can be accepted (FILL only)
//   flush_i    in   pulse: close partial frame (FILL) / abort display (SHOW)
//   step_i     in   pulse: advance to next entry now
//   hold_i     in   level: freeze the dwell count
//   valid_o    out  data_o/index_o show an entry
//   data_o     out  entry being shown (0 when not showing)
//   index_o    out  position of the shown entry
//   last_o     out  shown entry is the final one of the frame
module result_display_sequencer
  import result_display_pkg::*;
#(
  parameter int width_p = 8,
  parameter int depth_p = 4,
  parameter int dwell_p = DWELL_5S_12MHZ
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       valid_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  input  logic                       flush_i,
  input  logic                       step_i,
  input  logic                       hold_i,
  output logic                       valid_o,
  output logic [width_p-1:0]         data_o,
  output logic [$clog2(depth_p)-1:0] index_o,
  output logic                       last_o
);

  localparam int                  idx_w_lp   = $clog2(depth_p);
  localparam logic [idx_w_lp-1:0] top_idx_lp = idx_w_lp'(depth_p - 1);

  state_e              state_q, state_d;
  logic [idx_w_lp-1:0] count_q, count_d;
  logic [idx_w_lp-1:0] rd_q, rd_d;
  logic [idx_w_lp-1:0] last_q, last_d;   // index of the final entry of the frame
  logic                ready_q, ready_d;
  logic [width_p-1:0]  mem_q [depth_p];

  logic accept;
  logic expire;
  logic clear;
  logic advance;

  assign accept  = (state_q == FILL) && valid_i && ready_q;
  assign advance = expire || step_i;

  dwell_timer #(
    .dwell_p (dwell_p)
  ) u_dwell_timer (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (clear),
    .hold_i    (hold_i),
    .expire_o  (expire)
  );

  // Buffer has no reset; it is only observable while showing.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem_q[count_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= FILL;
      count_q <= '0;
      rd_q    <= '0;
      last_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      last_q  <= last_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rd_d    = rd_q;
    last_d  = last_q;
    ready_d = ready_q;
    clear   = 1'b0;

    unique case (state_q)
      FILL: begin
        // Dwell is held at zero while filling so the first entry gets a full period.
        clear   = 1'b1;
        ready_d = 1'b1;
        if (accept && (count_q == top_idx_lp)) begin
          state_d = SHOW;
          last_d  = top_idx_lp;
          count_d = '0;
          rd_d    = '0;
          ready_d = 1'b0;
        end else if (flush_i && (accept || (count_q != '0))) begin
          // A same-cycle accept lands at mem[count], so it becomes the last entry.
          state_d = SHOW;
          last_d  = accept ? count_q : count_q - idx_w_lp'(1);
          count_d = '0;
          rd_d    = '0;
          ready_d = 1'b0;
        end else if (accept) begin
          count_d = count_q + idx_w_lp'(1);
        end
      end

      SHOW: begin
        if (flush_i) begin
          state_d = FILL;
          rd_d    = '0;
          count_d = '0;
          ready_d = 1'b1;
          clear   = 1'b1;
        end else if (advance) begin
          clear = 1'b1;
          if (rd_q == last_q) begin
`ifdef RESULT_DISPLAY_LOOP_EN
            rd_d    = '0;
`else
            state_d = FILL;
            rd_d    = '0;
            count_d = '0;
            ready_d = 1'b1;
`endif
          end else begin
            rd_d = rd_q + idx_w_lp'(1);
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_comb begin
    valid_o = (state_q == SHOW);
    ready_o = ready_q;
    index_o = rd_q;
    last_o  = (state_q == SHOW) && (rd_q == last_q);
    data_o  = (state_q == SHOW) ? mem_q[rd_q] : '0;
  end

endmodule

// File: tb/tb_result_display_sequencer.sv
// tb/tb_result_display_sequencer.sv - self-checking bench for result_display_sequencer
module tb_result_display_sequencer;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int DW = 3;

  logic         clk_i     = 1'b0;
  logic         reset_n_i = 1'b0;
  logic         valid_i   = 1'b0;
  logic [W-1:0] data_i    = '0;
  logic         flush_i   = 1'b0;
  logic         step_i    = 1'b0;
  logic         hold_i    = 1'b0;
  logic         ready_o;
  logic         valid_o;
  logic [W-1:0] data_o;
  logic [1:0]   index_o;
  logic         last_o;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] frame_q[$];

  always #5 clk_i = ~clk_i;

  result_display_sequencer #(
    .width_p (W),
    .depth_p (D),
    .dwell_p (DW)
  ) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .valid_i   (valid_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .flush_i   (flush_i),
    .step_i    (step_i),
    .hold_i    (hold_i),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .index_o   (index_o),
    .last_o    (last_o)
  );

  // Feed frame_q; ends at the negedge after the last accept.
  task automatic load_frame(input bit do_flush);
    for (int i = 0; i < frame_q.size(); i++) begin
      valid_i = 1'b1;
      data_i  = frame_q[i];
      @(negedge clk_i);
    end
    valid_i = 1'b0;
    if (do_flush) begin
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
    end
  endtask

  task automatic randomize_frame(input int n);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(W'($urandom));
  endtask

  // Entry k/DW of the frame is on display during show cycle k.
  task automatic expect_one_pass(input string tag);
    int len;
    int e;
    len = frame_q.size();
    for (int k = 0; k < len * DW; k++) begin
      e = k / DW;
      checks++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0) begin
        failures++;
        $display("FAIL %s_valid k=%0d got valid=%b ready=%b want valid=1 ready=0", tag, k, valid_o, ready_o);
      end
      checks++;
      if (index_o !== 2'(e) || data_o !== frame_q[e]) begin
        failures++;
        $display("FAIL %s_entry k=%0d got idx=%0d data=%h want idx=%0d data=%h", tag, k, index_o, data_o, e, frame_q[e]);
      end
      checks++;
      if (last_o !== (e == len - 1)) begin
        failures++;
        $display("FAIL %s_last k=%0d got %b want %b", tag, k, last_o, (e == len - 1));
      end
      @(negedge clk_i);
    end
  endtask

  task automatic expect_fill(input string tag);
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || last_o !== 1'b0 || index_o !== 2'd0 || data_o !== '0) begin
      failures++;
      $display("FAIL %s_fill got valid=%b ready=%b last=%b idx=%0d data=%h want 0 1 0 0 00",
               tag, valid_o, ready_o, last_o, index_o, data_o);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (ready_o !== 1'b0 || valid_o !== 1'b0 || data_o !== '0 || index_o !== 2'd0 || last_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got ready=%b valid=%b data=%h idx=%0d last=%b want all zero",
               ready_o, valid_o, data_o, index_o, last_o);
    end
    #21 reset_n_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_before_edge got %b want 0", ready_o);
    end
    @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after_edge got %b want 1", ready_o);
    end
  endtask

  task automatic test_full_frame;
    frame_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_frame(1'b0);
    expect_one_pass("full_fixed");
    expect_fill("full_fixed_end");
    for (int r = 0; r < 2; r++) begin
      randomize_frame(D);
      load_frame(1'b0);
      expect_one_pass("full_rand");
      expect_fill("full_rand_end");
    end
  endtask

  task automatic test_partial_frame;
    frame_q = '{8'hA1, 8'hA2};
    load_frame(1'b1);
    expect_one_pass("partial_fixed");
    expect_fill("partial_fixed_end");
    for (int r = 0; r < 3; r++) begin
      randomize_frame(1 + int'($urandom_range(2)));
      load_frame(1'b1);
      expect_one_pass("partial_rand");
      expect_fill("partial_rand_end");
    end
    // flush on an empty buffer must be ignored
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_fill("empty_flush");
      @(negedge clk_i);
    end
  endtask

  task automatic test_hold_step;
    randomize_frame(D);
    load_frame(1'b0);
    repeat (DW) @(negedge clk_i);
    hold_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (index_o !== 2'd1 || data_o !== frame_q[1]) begin
        failures++;
        $display("FAIL hold_index cyc=%0d got idx=%0d data=%h want 1 %h", i, index_o, data_o, frame_q[1]);
      end
      @(negedge clk_i);
    end
    step_i = 1'b1;
    @(negedge clk_i);
    step_i = 1'b0;
    hold_i = 1'b0;
    // index 2 starts a fresh dwell; step on its expiry cycle (age DW-1)
    for (int a = 0; a < DW; a++) begin
      checks++;
      if (index_o !== 2'd2) begin
        failures++;
        $display("FAIL step_index age=%0d got %0d want 2", a, index_o);
      end
      if (a == DW - 1) step_i = 1'b1;
      @(negedge clk_i);
    end
    step_i = 1'b0;
    for (int a = 0; a < DW; a++) begin
      checks++;
      if (index_o !== 2'd3 || valid_o !== 1'b1 || last_o !== 1'b1) begin
        failures++;
        $display("FAIL step_single_advance age=%0d got idx=%0d valid=%b last=%b want 3 1 1", a, index_o, valid_o, last_o);
      end
      @(negedge clk_i);
    end
    expect_fill("step_end");
  endtask

  task automatic test_abort;
    randomize_frame(D);
    load_frame(1'b0);
    repeat (3 * DW - 1) @(negedge clk_i);
    checks++;
    if (index_o !== 2'd2) begin
      failures++;
      $display("FAIL abort_setup got idx=%0d want 2", index_o);
    end
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    expect_fill("abort");
    // count restarted at zero: three entries must not open a frame, four must
    randomize_frame(D);
    for (int i = 0; i < D; i++) begin
      checks++;
      if (valid_o !== 1'b0) begin
        failures++;
        $display("FAIL abort_count entry=%0d got valid=%b want 0", i, valid_o);
      end
      valid_i = 1'b1;
      data_i  = frame_q[i];
      @(negedge clk_i);
    end
    valid_i = 1'b0;
    expect_one_pass("after_abort");
    expect_fill("after_abort_end");
  endtask

  task automatic test_async_reset;
    randomize_frame(D);
    load_frame(1'b0);
    repeat (DW + 1) @(negedge clk_i);
    #2 reset_n_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b0 || valid_o !== 1'b0 || data_o !== '0 || index_o !== 2'd0 || last_o !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got ready=%b valid=%b data=%h idx=%0d last=%b want all zero",
               ready_o, valid_o, data_o, index_o, last_o);
    end
    @(negedge clk_i);
    #2 reset_n_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b0) begin
      failures++;
      $display("FAIL async_release_before_edge got %b want 0", ready_o);
    end
    @(negedge clk_i);
    expect_fill("async_release");
    frame_q = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};
    load_frame(1'b0);
    expect_one_pass("post_reset");
    expect_fill("post_reset_end");
  endtask

  task automatic test_loop;
    randomize_frame(D);
    load_frame(1'b0);
    for (int k = 0; k < 2 * D * DW + DW + 1; k++) begin
      checks++;
      if (valid_o !== 1'b1 || index_o !== 2'((k / DW) % D) || data_o !== frame_q[(k / DW) % D]) begin
        failures++;
        $display("FAIL loop_seq k=%0d got valid=%b idx=%0d data=%h want 1 %0d %h",
                 k, valid_o, index_o, data_o, (k / DW) % D, frame_q[(k / DW) % D]);
      end
      @(negedge clk_i);
    end
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    expect_fill("loop_exit");
  endtask

  initial begin
    test_reset;
`ifdef RESULT_DISPLAY_LOOP_EN
    test_loop;
`else
    test_full_frame;
    test_partial_frame;
    test_hold_step;
    test_abort;
    test_async_reset;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_display_sequencer.md
# result_display_sequencer

Parametrised frame buffer and display sequencer between the systolic array result stream and the two-digit seven-segment driver. It accepts `width_p`-bit results over a valid/ready handshake until a frame of `depth_p` entries is full or `flush_i` closes a partial frame. It then presents each entry for `dwell_p` cycles, or until a manual `step_i` advance. This replaces the ad hoc display flag, the five-second divider and the edge-detector chain with one block that takes runtime hold, step and abort controls.

## Interface
- `width_p`, 8, bits per result entry
- `depth_p`, 4, entries per frame; must be ≥2
- `dwell_p`, 60_000_000, cycles each entry is shown; ≥1 (5 s at 12 MHz)
- `clk_i`  in  1  single clock, rising edge
- `reset_n_i`  in  1  reset; asynchronous, active-low
- `valid_i`  in  1  result on `data_i` is valid
- `data_i`  in  `width_p`  result entry
- `ready_o`  out  1  block can accept an entry
- `flush_i`  in  1  single-cycle pulse: close a partial frame (FILL) or abort display (SHOW)
- `step_i`  in  1  single-cycle pulse: advance to the next entry now
- `hold_i`  in  1  level; freezes the dwell count
- `valid_o`  out  1  `data_o`/`index_o` hold a displayed entry
- `data_o`  out  `width_p`  entry currently shown
- `index_o`  out  `$clog2(depth_p)`  position of the shown entry in the frame
- `last_o`  out  1  shown entry is the final entry of the frame

## Operation
- **States:** FILL and SHOW. Reset enters FILL with count=0, rd=0, dwell=0.
- **Reset values:** `ready_o`=0, `valid_o`=0, `data_o`=0, `index_o`=0, `last_o`=0. `ready_o` is registered and rises on the first edge after `reset_n_i` deasserts.
- **FILL accept:** an entry is taken when `valid_i & ready_o`. It is written to mem[count] and count increments.
- **FILL to SHOW (full frame):** on the edge that accepts entry `depth_p`-1. Frame length = `depth_p`.
- **FILL to SHOW (partial frame):** `flush_i` with count>0 goes to SHOW. Frame length = count, plus 1 if an accept happens in the same cycle. `flush_i` with count=0 and no accept is ignored.
- **SHOW outputs:** `valid_o`=1, `data_o`=mem[rd], `index_o`=rd, `last_o`=(rd==len-1). `ready_o`=0. `valid_i` is ignored.
- **Dwell:** the counter increments each cycle unless `hold_i` is high.
  - Expiry happens at dwell==`dwell_p`-1 with `hold_i` low.
  - An advance occurs on expiry or on `step_i`, whichever comes first. `step_i` is honoured even while `hold_i` is high.
  - Expiry and `step_i` in the same cycle produce one advance.
  - Every advance clears dwell.
- **Advance, not last entry:** rd increments.
- **Advance on last entry:** return to FILL with count=0, rd=0. `valid_o`/`last_o` fall and `ready_o` rises.
- **Abort:** `flush_i` in SHOW returns to FILL immediately and discards the frame. It takes priority over an advance in the same cycle.
- **Reset mid-operation:** asynchronous return to reset values. Buffer contents are not cleared and are not observable.

## Timing
- Accept to storage: the entry is written on the accepting edge.
- Full frame: the edge accepting the final entry sets `valid_o`=1 and `index_o`=0. The first entry is visible the next cycle.
- Auto-advance: each entry is shown for exactly `dwell_p` cycles when `hold_i` is low. A frame of length L occupies L×`dwell_p` cycles.
- Step: `step_i` sampled high at edge t gives the new `index_o` after t.
- End of frame: `ready_o` is 1 the cycle after the final advance. Earliest next accept is that cycle.
- All outputs are registered or derived from registered state; there are no input-to-output combinational paths.

## Configuration
- **With `RESULT_DISPLAY_LOOP_EN` defined:** advancing from the last entry wraps rd to 0 and stays in SHOW. The frame loops until `flush_i` aborts it.
- **Without `RESULT_DISPLAY_LOOP_EN`:** behaviour is as in Operation (one pass, then FILL).

## Structure
- **Package `result_display_pkg`:**
  - `state_e` typedef (FILL, SHOW)
  - `DWELL_5S_12MHZ` constant = 60_000_000
  - `dwell_width` function = `$clog2(dwell_p+1)`
- **Sub-module `dwell_timer`:**
  - Parameter: `dwell_p`.
  - Inputs: `clk_i`, `reset_n_i`, `clear_i`, `hold_i`.
  - Output: `expire_o`, a one-cycle pulse.
  - The sequencer drives `clear_i` on every advance, abort and FILL entry.

## Test plan
Bench parameters: `width_p`=8, `depth_p`=4, `dwell_p`=3.
- **Full frame:** feed 0x11, 0x22, 0x33, 0x44 back-to-back. Required: `data_o` shows 0x11, 0x22, 0x33, 0x44 for 3 cycles each; `last_o` is high only with 0x44; then `ready_o`=1 and `valid_o`=0.
- **Partial frame:** feed 0xA1, 0xA2, then `flush_i`. Required: two entries shown, `last_o` high on 0xA2, return to FILL. `flush_i` with an empty buffer leaves `ready_o`=1 with no SHOW.
- **Hold and step:** hold `hold_i` high for 10 cycles on index 1. Required: index stays 1. Pulse `step_i`: index goes to 2 next cycle. Pulse `step_i` on the expiry cycle: a single advance only.
- **Abort:** `flush_i` on index 2, in the same cycle as an expiry. Required: FILL next cycle, `valid_o`=0, `ready_o`=1, count=0.
- **Async reset:** assert `reset_n_i` low mid-SHOW, off a clock edge. Required: outputs at reset values immediately. After release, `ready_o`=1 one edge later.
- **Loop mode (`RESULT_DISPLAY_LOOP_EN`):** full frame. Required: index sequence 0, 1, 2, 3, 0, 1…, exited only by `flush_i`.
